// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer for the single-cycle core.
//
// Owns the architectural PC and keeps at most one instruction-memory request
// outstanding over a req/gnt/rvalid bus. Each fetched word is presented to
// decode/execute with a valid/ready handshake. On retire the next PC is PC+4,
// or the control-flow unit's redirect target. flush_i restarts fetch at
// flush_target_i from any state. A response already in flight during a flush
// is dropped.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a redirect/flush target with bits [1:0] != 0 parks the
//               sequencer in TRAP (trap_o/trap_pc_o) until the next flush.
//   undefined - bits [1:0] of every redirect/flush target are forced to 0;
//               trap_o and trap_pc_o are tied to 0.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   imem_req_o, imem_addr_o  fetch request / address (= PC), from registered state
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  read response
//   instr_valid_o, instr_o, instr_pc_o  registered instruction to decode
//   instr_ready_i            consumer retires the presented instruction
//   redirect_i, redirect_target_i  next-PC select, sampled only on retire
//   flush_i, flush_target_i  restart fetch at flush_target_i
//   trap_o, trap_pc_o        misaligned-target trap pending / offending target
//   instret_o                retired-instruction count (wraps)
module fetch_sequencer #(
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ResetVector = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [DataWidth-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i,
    output logic                 instr_valid_o,
    output logic [DataWidth-1:0] instr_o,
    output logic [DataWidth-1:0] instr_pc_o,
    input  logic                 instr_ready_i,
    input  logic                 redirect_i,
    input  logic [DataWidth-1:0] redirect_target_i,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] flush_target_i,
    output logic                 trap_o,
    output logic [DataWidth-1:0] trap_pc_o,
    output logic [DataWidth-1:0] instret_o
);

    localparam logic [2:0] BOOT = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] TRAP = 3'd4;
`endif

    logic [2:0]           state_q, state_d;
    logic [DataWidth-1:0] pc_q, pc_d;
    logic                 drop_q, drop_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [DataWidth-1:0] instr_pc_q, instr_pc_d;
    logic [DataWidth-1:0] instret_q, instret_d;
    logic                 take_new;
    logic [DataWidth-1:0] new_target;
    logic [DataWidth-1:0] applied_target;

    // Flush outranks redirect, so its target is the one taken when both apply.
    assign new_target = flush_i ? flush_target_i : redirect_target_i;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic                 trap_q, trap_d;
    logic [DataWidth-1:0] trap_pc_q, trap_pc_d;
    logic                 target_bad;

    assign target_bad     = |new_target[1:0];
    assign applied_target = new_target;
    assign trap_o         = trap_q;
    assign trap_pc_o      = trap_pc_q;
`else
    assign applied_target = new_target & ~{{(DataWidth-2){1'b0}}, 2'b11};
    assign trap_o         = 1'b0;
    assign trap_pc_o      = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        instret_d  = instret_q;
        take_new   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d     = trap_q;
        trap_pc_d  = trap_pc_q;
`endif
        if (flush_i) begin
            take_new = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_d   = 1'b0;
`endif
            case (state_q)
                // Granted request is still in flight: drain it before refetching.
                REQ: if (imem_gnt_i) begin
                    state_d = WAIT;
                    drop_d  = 1'b1;
                end
                WAIT: if (imem_rvalid_i) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                BOOT: state_d = REQ;
                REQ:  if (imem_gnt_i) state_d = WAIT;
                WAIT: if (imem_rvalid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
                        // Trap raised by the flush that caused the drop.
                        if (trap_q) state_d = TRAP;
`endif
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end
                HOLD: if (instr_ready_i) begin
                    instret_d = instret_q + DataWidth'(1);
                    state_d   = REQ;
                    if (redirect_i) take_new = 1'b1;
                    else            pc_d     = pc_q + DataWidth'(4);
                end
                default: ;
            endcase
        end

        if (take_new) begin
            pc_d = applied_target;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target_bad) begin
                trap_d    = 1'b1;
                trap_pc_d = new_target;
                if (state_d == REQ) state_d = TRAP;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            pc_q       <= ResetVector;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            instret_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
            trap_pc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            instret_q  <= instret_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= trap_d;
            trap_pc_q  <= trap_pc_d;
`endif
        end
    end

    assign imem_req_o    = (state_q == REQ);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rtarget = '0;
    logic        flush = 1'b0;
    logic [31:0] ftarget = '0;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    logic [31:0] exp_instret = '0;
    logic [63:0] sb[$];

    fetch_sequencer #(.DataWidth(32), .ResetVector(32'h0000_0100)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(ready),
        .redirect_i(redirect), .redirect_target_i(rtarget),
        .flush_i(flush), .flush_target_i(ftarget),
        .trap_o(trap), .trap_pc_o(trap_pc), .instret_o(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
        redirect = 1'b0; rtarget = '0; flush = 1'b0; ftarget = '0;
        tick(); tick();
        rst = 1'b0;
        rel_cyc = cyc;
        exp_instret = '0;
        sb.delete();
    endtask

    task automatic wait_req(output bit timeout);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        timeout = (imem_req !== 1'b1);
    endtask

    // Grant, answer after one cycle, then retire with the given redirect.
    task automatic fetch_and_retire(input logic [31:0] exp_addr, input logic redir,
                                    input logic [31:0] tgt, output logic [31:0] req_addr,
                                    output logic valid_seen, output logic [31:0] got_instr,
                                    output logic [31:0] got_pc, output int valid_cyc,
                                    output bit timeout);
        req_addr = 'x; valid_seen = 1'b0; got_instr = 'x; got_pc = 'x; valid_cyc = 0;
        wait_req(timeout);
        if (timeout) return;
        req_addr = imem_addr;
        sb.push_back({exp_addr, mem_word(exp_addr)});
        gnt = 1'b1; tick(); gnt = 1'b0;
        rdata = mem_word(req_addr); rvalid = 1'b1; tick(); rvalid = 1'b0; rdata = '0;
        valid_seen = instr_valid; got_instr = instr; got_pc = instr_pc; valid_cyc = cyc;
        redirect = redir; rtarget = tgt; ready = 1'b1; tick();
        ready = 1'b0; redirect = 1'b0;
        exp_instret++;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=00000100", imem_addr); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0/0", instr, instr_pc); end
        checks++; if (instret !== 32'h0) begin failures++; $display("FAIL reset_instret got=%h exp=0", instret); end
        checks++; if (trap !== 1'b0 || trap_pc !== 32'h0) begin failures++; $display("FAIL reset_trap got=%b/%h exp=0/0", trap, trap_pc); end
        rst = 1'b0;
        rel_cyc = cyc;
        exp_instret = '0;
        sb.delete();
    endtask

    task automatic test_fetch();
        logic [31:0] a, gi, gp; logic v; int vc; bit to; logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            fetch_and_retire(32'h100 + 32'(4 * i), 1'b0, '0, a, v, gi, gp, vc, to);
            checks++; if (to) begin failures++; $display("FAIL fetch_req_timeout got=none exp=req"); continue; end
            checks++; if (a !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", a, 32'h100 + 32'(4 * i)); end
            checks++; if (v !== 1'b1) begin failures++; $display("FAIL fetch_valid got=%b exp=1", v); end
            if (i == 0) begin
                checks++; if (vc - rel_cyc !== 3) begin failures++; $display("FAIL first_valid_latency got=%0d exp=3", vc - rel_cyc); end
            end
            e = sb.pop_front();
            checks++; if (gi !== e[31:0] || gp !== e[63:32]) begin failures++; $display("FAIL fetch_data got=%h@%h exp=%h@%h", gi, gp, e[31:0], e[63:32]); end
        end
        checks++; if (instret !== exp_instret) begin failures++; $display("FAIL fetch_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_redirect();
        logic [31:0] a, gi, gp; logic v; int vc; bit to; logic [63:0] e;
        do_reset();
        fetch_and_retire(32'h100, 1'b0, '0, a, v, gi, gp, vc, to);
        void'(sb.pop_front());
        fetch_and_retire(32'h104, 1'b1, 32'h200, a, v, gi, gp, vc, to);
        e = sb.pop_front();
        checks++; if (gp !== e[63:32]) begin failures++; $display("FAIL redir_src_pc got=%h exp=%h", gp, e[63:32]); end
        wait_req(to);
        checks++; if (to || imem_addr !== 32'h200) begin failures++; $display("FAIL redir_addr got=%h exp=00000200", imem_addr); end
        sb.push_back({32'h200, mem_word(32'h200)});
        gnt = 1'b1; tick(); gnt = 1'b0;
        redirect = 1'b1; rtarget = 32'h500; tick(); redirect = 1'b0; rtarget = '0;
        rdata = mem_word(imem_addr); rvalid = 1'b1; tick(); rvalid = 1'b0;
        e = sb.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr !== e[31:0] || instr_pc !== e[63:32]) begin
            failures++; $display("FAIL redir_data got=%b %h@%h exp=1 %h@%h", instr_valid, instr, instr_pc, e[31:0], e[63:32]); end
        ready = 1'b1; tick(); ready = 1'b0; exp_instret++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin failures++; $display("FAIL redir_wait_ignored got=%b %h exp=1 00000204", imem_req, imem_addr); end
        checks++; if (instret !== exp_instret) begin failures++; $display("FAIL redir_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_backpressure();
        bit to; logic [63:0] e;
        do_reset();
        wait_req(to);
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL gnt_hold got=%b %h exp=1 00000100", imem_req, imem_addr); end
            tick();
        end
        sb.push_back({32'h100, mem_word(32'h100)});
        gnt = 1'b1; tick(); gnt = 1'b0;
        rdata = mem_word(32'h100); rvalid = 1'b1; tick(); rvalid = 1'b0; rdata = '0;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1 || instr !== e[31:0] || instret !== exp_instret) begin
                failures++; $display("FAIL ready_hold got=%b %h %0d exp=1 %h %0d", instr_valid, instr, instret, e[31:0], exp_instret); end
            tick();
        end
        ready = 1'b1; tick(); ready = 1'b0; exp_instret++;
        checks++; if (instret !== exp_instret || imem_addr !== 32'h104) begin
            failures++; $display("FAIL bp_retire got=%0d %h exp=%0d 00000104", instret, imem_addr, exp_instret); end
    endtask

    task automatic test_flush_wait();
        logic [31:0] a, gi, gp; logic v; int vc; bit to; logic [63:0] e;
        do_reset();
        wait_req(to);
        gnt = 1'b1; tick(); gnt = 1'b0;
        flush = 1'b1; ftarget = 32'h300; tick(); flush = 1'b0;
        rdata = 32'hDEAD_BEEF; rvalid = 1'b1; tick(); rvalid = 1'b0; rdata = '0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            failures++; $display("FAIL flush_wait_drop got=%b %b %h exp=0 1 00000300", instr_valid, imem_req, imem_addr); end
        fetch_and_retire(32'h300, 1'b0, '0, a, v, gi, gp, vc, to);
        e = sb.pop_front();
        checks++; if (v !== 1'b1 || gi !== e[31:0] || gp !== e[63:32]) begin
            failures++; $display("FAIL flush_wait_data got=%b %h@%h exp=1 %h@%h", v, gi, gp, e[31:0], e[63:32]); end
        checks++; if (instret !== exp_instret) begin failures++; $display("FAIL flush_wait_instret got=%0d exp=%0d", instret, exp_instret); end
    endtask

    task automatic test_flush_req_grant();
        bit to;
        do_reset();
        wait_req(to);
        gnt = 1'b1; flush = 1'b1; ftarget = 32'h380; tick(); gnt = 1'b0; flush = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL flush_gnt_wait got=%b exp=0", imem_req); end
        rdata = 32'hBAD0_BAD0; rvalid = 1'b1; tick(); rvalid = 1'b0; rdata = '0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h380) begin
            failures++; $display("FAIL flush_gnt_drop got=%b %b %h exp=0 1 00000380", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_flush_hold();
        bit to; logic [63:0] e;
        do_reset();
        wait_req(to);
        sb.push_back({32'h100, mem_word(32'h100)});
        gnt = 1'b1; tick(); gnt = 1'b0;
        rdata = mem_word(32'h100); rvalid = 1'b1; tick(); rvalid = 1'b0; rdata = '0;
        e = sb.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr !== e[31:0]) begin failures++; $display("FAIL hold_data got=%b %h exp=1 %h", instr_valid, instr, e[31:0]); end
        flush = 1'b1; ftarget = 32'h340; ready = 1'b1; redirect = 1'b1; rtarget = 32'h600; tick();
        flush = 1'b0; ready = 1'b0; redirect = 1'b0;
        checks++; if (instret !== exp_instret) begin failures++; $display("FAIL flush_hold_instret got=%0d exp=%0d", instret, exp_instret); end
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h340) begin
            failures++; $display("FAIL flush_hold_next got=%b %b %h exp=0 1 00000340", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        logic [31:0] a, gi, gp; logic v; int vc; bit to; logic [63:0] e;
        do_reset();
        fetch_and_retire(32'h100, 1'b1, 32'h202, a, v, gi, gp, vc, to);
        void'(sb.pop_front());
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (trap !== 1'b1 || trap_pc !== 32'h202) begin failures++; $display("FAIL trap_set got=%b %h exp=1 00000202", trap, trap_pc); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL trap_no_req got=%b exp=0", imem_req); end
            tick();
        end
        flush = 1'b1; ftarget = 32'h400; tick(); flush = 1'b0;
        checks++; if (trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            failures++; $display("FAIL trap_clear got=%b %b %h exp=0 1 00000400", trap, imem_req, imem_addr); end
        fetch_and_retire(32'h400, 1'b0, '0, a, v, gi, gp, vc, to);
        e = sb.pop_front();
        checks++; if (v !== 1'b1 || gp !== e[63:32] || gi !== e[31:0]) begin
            failures++; $display("FAIL trap_refetch got=%b %h@%h exp=1 %h@%h", v, gi, gp, e[31:0], e[63:32]); end
`else
        checks++; if (trap !== 1'b0 || trap_pc !== 32'h0) begin failures++; $display("FAIL no_trap got=%b %h exp=0 0", trap, trap_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL align_addr got=%b %h exp=1 00000200", imem_req, imem_addr); end
        fetch_and_retire(32'h200, 1'b0, '0, a, v, gi, gp, vc, to);
        e = sb.pop_front();
        checks++; if (v !== 1'b1 || gp !== e[63:32] || gi !== e[31:0]) begin
            failures++; $display("FAIL align_fetch got=%b %h@%h exp=1 %h@%h", v, gi, gp, e[31:0], e[63:32]); end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_redirect();
        test_backpressure();
        test_flush_wait();
        test_flush_req_grant();
        test_flush_hold();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
